// File: rtl/sound_pkg.sv
// Shared constants and types for the piezo sound scheduler.
// Note values are half-period P in 50 MHz cycles (half-period lasts P+1 cycles).
package sound_pkg;

    localparam int PER_W = 20;

    localparam int SRC_HORN    = 0;
    localparam int SRC_CLICK   = 1;
    localparam int SRC_REVERSE = 2;
    localparam int SRC_ENGINE  = 3;

    localparam logic [PER_W-1:0] NOTE_REST = 20'd0;
    localparam logic [PER_W-1:0] NOTE_C4   = 20'd95555;
    localparam logic [PER_W-1:0] NOTE_D4   = 20'd85130;
    localparam logic [PER_W-1:0] NOTE_E4   = 20'd75842;
    localparam logic [PER_W-1:0] NOTE_F4   = 20'd71585;
    localparam logic [PER_W-1:0] NOTE_G4   = 20'd63775;
    localparam logic [PER_W-1:0] NOTE_A4   = 20'd56817;
    localparam logic [PER_W-1:0] NOTE_B4   = 20'd50618;
    localparam logic [PER_W-1:0] NOTE_C5   = 20'd47777;
    localparam logic [PER_W-1:0] NOTE_D5   = 20'd42564;
    localparam logic [PER_W-1:0] NOTE_E5   = 20'd37920;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/sound_tone_gen.sv
// Square-wave generator: counter 0..P, wave toggles at cnt==P where P also reloads.
// A latched P of 0 is a rest: wave and counter stay at 0.
module sound_tone_gen
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             force_low,
    input  logic [PER_W-1:0] period,
    output logic             wave,
    output logic             at_edge
);

    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             wave_q, wave_d;

    assign at_edge = (cnt_q == per_q);
    assign wave    = wave_q;

    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        wave_d = wave_q;
        if (load) begin
            cnt_d  = '0;
            per_d  = period;
            wave_d = 1'b0;
        end else if (run) begin
            if (at_edge) begin
                cnt_d = '0;
                per_d = period;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Decided from the old P so a reload to rest still ends the current half cleanly.
            if (force_low || per_q == '0) begin
                wave_d = 1'b0;
            end else if (at_edge) begin
                wave_d = ~wave_q;
            end
        end else begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            per_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            wave_q <= wave_d;
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Priority arbiter for the single piezo pin: lowest index wins, sources only change
// at waveform boundaries followed by a silence gap.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int ONESHOT_CYC = 150_000,
    parameter int GAP_CYC     = 50_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC-1:0]         trig,
    input  logic [NUM_SRC*PER_W-1:0]   period_in,
    output logic                       piezo_out,
    output logic [$clog2(NUM_SRC)-1:0] active_src,
    output logic                       busy,
    output logic                       playing,
    output state_e                     dbg_state
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int OS_W  = $clog2(ONESHOT_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [OS_W-1:0]    os_q [NUM_SRC];
    logic [OS_W-1:0]    os_d [NUM_SRC];
    logic [NUM_SRC-1:0] active;
    logic [SRC_W-1:0]   winner;
    logic               none_active;
    logic               load, run, force_low, do_eval;
    logic               wave, at_edge;
    logic [SRC_W-1:0]   sel_src;
    logic [PER_W-1:0]   period_sel;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (trig[i]) begin
                os_d[i] = OS_W'(ONESHOT_CYC);
            end else if (os_q[i] != '0) begin
                os_d[i] = os_q[i] - 1'b1;
            end else begin
                os_d[i] = '0;
            end
            active[i] = req[i] | (os_q[i] != '0);
        end
    end

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = SRC_W'(i);
        end
        none_active = ~|active;
    end

    // A fresh load takes the winner's period; otherwise reloads follow the owner.
    assign sel_src    = load ? winner : src_q;
    assign period_sel = period_in[int'(sel_src)*PER_W +: PER_W];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        gap_d     = gap_q;
        load      = 1'b0;
        run       = 1'b0;
        force_low = 1'b0;
        do_eval   = 1'b0;
        case (state_q)
            IDLE: do_eval = 1'b1;
            PLAY: begin
                run = 1'b1;
                if (none_active || winner != src_q) state_d = DRAIN;
            end
            DRAIN: begin
                run = 1'b1;
                if (!none_active && winner == src_q) begin
                    state_d = PLAY;
                end else if (!wave || at_edge) begin
                    force_low = 1'b1;
                    if (GAP_CYC == 0) begin
                        do_eval = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) do_eval = 1'b1;
                else gap_d = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (do_eval) begin
            state_d = IDLE;
            if (!none_active) begin
                load    = 1'b1;
                src_d   = winner;
                state_d = PLAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            gap_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) os_q[i] <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            gap_q   <= gap_d;
            for (int i = 0; i < NUM_SRC; i++) os_q[i] <= os_d[i];
        end
    end

    sound_tone_gen u_tone (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .run       (run),
        .force_low (force_low),
        .period    (period_sel),
        .wave      (wave),
        .at_edge   (at_edge)
    );

    assign piezo_out  = wave;
    assign active_src = src_q;
    assign busy       = (state_q != IDLE);
    assign playing    = (state_q == PLAY);
    assign dbg_state  = state_q;

endmodule
